// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: instruction stream and register-file/ALU control bus of the sequencer
//   instr, instr_valid, instr_ready : micro-instruction valid/ready stream
//   a_addr, b_addr, d_addr, wr_en    : register file read/write addressing and write strobe
//   func_sel, mux_b_sel, const_data  : ALU function, B-operand select and immediate
interface datapath_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
);
   logic [15:0]           instr;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic                  wr_en;
   logic [3:0]            func_sel;
   logic                  mux_b_sel;
   logic [DATA_WIDTH-1:0] const_data;
   modport master (
      output instr, instr_valid,
      input  instr_ready, a_addr, b_addr, d_addr, wr_en, func_sel, mux_b_sel, const_data
   );
   modport slave (
      input  instr, instr_valid,
      output instr_ready, a_addr, b_addr, d_addr, wr_en, func_sel, mux_b_sel, const_data
   );
endinterface

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: decodes 16-bit micro-instructions and sequences the 8x16 register file + ALU
//   clk, rst_n     clock, asynchronous active-low reset
//   bus (slave)    instruction stream in; register addresses, wr_en, func_sel, mux_b_sel, const_data out
//   i_resume       leaves HALTED (only looked at while halted)
//   o_done         one-cycle pulse per retired instruction
//   o_illegal      pulse coincident with o_done for opcodes 9..E
//   o_halted       high while halted
//   o_instr_count  retired-instruction count, wraps
module datapath_sequencer #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 3,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   datapath_sequencer_if.slave    bus,
   input  logic                   i_resume,
   output logic                   o_done,
   output logic                   o_illegal,
   output logic                   o_halted,
   output logic [COUNT_WIDTH-1:0] o_instr_count
);
   typedef enum logic [2:0] {S_IDLE, S_OPER, S_WRITE, S_SHOP, S_HALTED} state_t;
   state_t                 r_state, w_next;
   logic [3:0]             r_op, r_func, w_op;
   logic [2:0]             r_cnt;
   logic [ADDR_WIDTH-1:0]  r_a, r_b, r_d;
   logic                   r_mux, r_ready, r_wr, r_done, r_ill, r_halted;
   logic [DATA_WIDTH-1:0]  r_const;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   w_accept, w_wr, w_done, w_ill, w_shop;
   assign w_op = bus.instr[15:12];
   // r_cnt holds the writes still owed: imm3 for SHL, 1 for every other writing op,
   // so the final write (and done) is always the one taken with r_cnt == 1
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_wr     = 1'b0;
      w_done   = 1'b0;
      w_ill    = 1'b0;
      w_shop   = 1'b0;
      case (r_state)
         S_IDLE:
            if (bus.instr_valid && r_ready) begin
               w_accept = 1'b1;
               w_next   = S_OPER;
            end
         S_OPER:
            if (r_op == 4'hF) begin
               w_next = S_HALTED;
               w_done = 1'b1;
            end else if ((r_op >= 4'd1 && r_op <= 4'd7) || (r_op == 4'd8 && r_cnt != 3'd0)) begin
               w_next = S_WRITE;
               w_wr   = 1'b1;
               w_done = r_cnt == 3'd1;
            end else begin
               w_next = S_IDLE;
               w_done = 1'b1;
               w_ill  = r_op >= 4'd9;
            end
         S_WRITE: begin
            w_shop = r_cnt != 3'd0;
            w_next = w_shop ? S_SHOP : S_IDLE;
         end
         S_SHOP: begin
            w_next = S_WRITE;
            w_wr   = 1'b1;
            w_done = r_cnt == 3'd1;
         end
         S_HALTED:
            if (i_resume) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_op     <= '0;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_d      <= '0;
         r_func   <= '0;
         r_mux    <= 1'b0;
         r_const  <= '0;
         r_ready  <= 1'b0;
         r_wr     <= 1'b0;
         r_done   <= 1'b0;
         r_ill    <= 1'b0;
         r_halted <= 1'b0;
         r_count  <= '0;
      end else begin
         r_ready  <= w_next == S_IDLE;
         r_wr     <= w_wr;
         r_done   <= w_done;
         r_ill    <= w_ill;
         r_halted <= w_next == S_HALTED;
         r_count  <= r_count + COUNT_WIDTH'(w_done);
         if (w_wr) r_cnt <= r_cnt - 3'd1;
         // after the first shift the destination becomes its own source
         if (w_shop) r_a <= r_d;
         if (w_accept) begin
            r_op    <= w_op;
            r_cnt   <= (w_op == 4'd8) ? bus.instr[2:0] : 3'd1;
            r_d     <= ADDR_WIDTH'(bus.instr[11:9]);
            r_a     <= ADDR_WIDTH'(bus.instr[8:6]);
            r_b     <= ADDR_WIDTH'(bus.instr[5:3]);
            r_func  <= (w_op >= 4'd2 && w_op <= 4'd6) ? w_op - 4'd1 : (w_op == 4'd8) ? 4'd6 : 4'd0;
            r_mux   <= w_op == 4'd7;
            r_const <= DATA_WIDTH'(bus.instr[2:0]);
         end
      end
   assign bus.instr_ready = r_ready;
   assign bus.a_addr      = r_a;
   assign bus.b_addr      = r_b;
   assign bus.d_addr      = r_d;
   assign bus.wr_en       = r_wr;
   assign bus.func_sel    = r_func;
   assign bus.mux_b_sel   = r_mux;
   assign bus.const_data  = r_const;
   assign o_done          = r_done;
   assign o_illegal       = r_ill;
   assign o_halted        = r_halted;
   assign o_instr_count   = r_count;
endmodule
